alu_flags_branch_unit: RTL

//  Consumer side of the 64-bit ALU: takes operands a/b1, result, zero and ALUControl, holds NZCV in a

---
 rtl/alu_flags_branch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_flags_branch_unit.sv
// NZCV flag register and registered branch resolver (B.cond, CBZ, CBNZ).
// It sits between the execute-stage ALU and the PC-select logic.
module alu_flags_branch_unit #(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b1,
   input  logic [3:0]   ALUControl,
   input  logic [N-1:0] result,
   input  logic         zero,
   input  logic         setFlags,
   input  logic         isCondBr,
   input  logic         isCbz,
   input  logic         isCbnz,
   input  logic [3:0]   cond,
   input  logic         flush,
   output logic [3:0]   flags,
   output logic         br_valid,
   output logic         br_taken,
   output logic         bad_op
);

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;

   logic [3:0]   r_flags;
   logic         r_br_valid;
   logic         r_br_taken;
   logic         r_bad_op;

   logic [N-1:0] w_add_lo;
   logic         w_add_c;
   logic         w_sub_c;
   logic [3:0]   w_flags_upd;
   logic         w_op_ok;
   logic         w_fn, w_fz, w_fc, w_fv;
   logic         w_base;
   logic         w_cond_true;
   logic         w_any_br;
   logic         w_multi_br;
   logic         w_illegal;
   logic         w_bad_alu;
   logic         w_take;
   logic         w_br_fire;
   logic         w_unused_result;

   // N and Z come from the ALU's own result/zero; only the MSB of result is needed here.
   assign w_unused_result = ^result[N-2:0];

   // Carry of a+b1 is a wrap-around; carry of a-b1 is "no borrow", i.e. a >= b1 unsigned.
   assign w_add_lo = a + b1;
   assign w_add_c  = (w_add_lo < a);
   assign w_sub_c  = (a >= b1);

   always_comb begin
      w_flags_upd = r_flags;
      w_op_ok     = 1'b1;
      case (ALUControl)
         OpAdd: w_flags_upd = {result[N-1], zero, w_add_c,
                               (a[N-1] == b1[N-1]) & (result[N-1] != a[N-1])};
         OpSub: w_flags_upd = {result[N-1], zero, w_sub_c,
                               (a[N-1] != b1[N-1]) & (result[N-1] != a[N-1])};
         OpAnd: w_flags_upd = {result[N-1], zero, 2'b00};
         default: w_op_ok = 1'b0;
      endcase
   end

   // Conditions come in pairs: cond[3:1] selects the test, cond[0] inverts it (except AL/NV).
   assign {w_fn, w_fz, w_fc, w_fv} = r_flags;

   always_comb begin
      w_base = 1'b1;
      case (cond[3:1])
         3'b000:  w_base = w_fz;
         3'b001:  w_base = w_fc;
         3'b010:  w_base = w_fn;
         3'b011:  w_base = w_fv;
         3'b100:  w_base = w_fc & ~w_fz;
         3'b101:  w_base = (w_fn == w_fv);
         3'b110:  w_base = ~w_fz & (w_fn == w_fv);
         default: w_base = 1'b1;
      endcase
   end

   assign w_cond_true = (cond[3:1] == 3'b111) ? 1'b1 : (w_base ^ cond[0]);

   assign w_any_br   = isCondBr | isCbz | isCbnz;
   assign w_multi_br = (isCondBr & isCbz) | (isCondBr & isCbnz) | (isCbz & isCbnz);
   assign w_illegal  = valid & (w_multi_br | (setFlags & w_any_br));
   assign w_bad_alu  = valid & setFlags & ~w_op_ok;

   always_comb begin
      w_take = 1'b0;
      if (isCondBr)   w_take = w_cond_true;
      else if (isCbz) w_take = zero;
      else if (isCbnz) w_take = ~zero;
   end

   assign w_br_fire = valid & w_any_br & ~flush & ~w_illegal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags    <= 4'b0000;
         r_br_valid <= 1'b0;
         r_br_taken <= 1'b0;
         r_bad_op   <= 1'b0;
      end else begin
         if (valid & setFlags & w_op_ok) r_flags <= w_flags_upd;
         r_br_valid <= w_br_fire;
         r_br_taken <= w_br_fire & w_take;
         r_bad_op   <= w_illegal | w_bad_alu;
      end
   end

   assign flags    = r_flags;
   assign br_valid = r_br_valid;
   assign br_taken = r_br_taken;
   assign bad_op   = r_bad_op;

endmodule
